// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand width.
package serial_subtractor_pkg;

   localparam int unsigned DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = a - b - bi, with borrow-out bo.
// Purely combinational; the serial datapath keeps all state.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bi,
   output logic d,
   output logic bo
);

   assign d  = a ^ b ^ bi;
   assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one bit per clock.
// Valid/ready on both sides; result holds in DONE until taken.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e state_q, state_d;

   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_q, b_q, diff_q;
   logic             br_q, bout_q, ovf_q;
   logic             d_bit, bo_bit;
   logic             capture, step, last;

   full_subtractor u_fs (
      .a  (a_q[0]),
      .b  (b_q[0]),
      .bi (br_q),
      .d  (d_bit),
      .bo (bo_bit)
   );

   assign last = (cnt_q == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      capture   = 1'b0;
      step      = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               capture = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            step = 1'b1;
            if (last) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operands shift right so bit 0 always feeds the full subtractor
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         br_q   <= 1'b0;
         diff_q <= '0;
         bout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (capture) begin
         cnt_q <= '0;
         a_q   <= a;
         b_q   <= b;
         br_q  <= bin;
      end else if (step) begin
         cnt_q  <= cnt_q + CW'(1);
         a_q    <= a_q >> 1;
         b_q    <= b_q >> 1;
         br_q   <= bo_bit;
         diff_q <= {d_bit, diff_q[WIDTH-1:1]};
         if (last) begin
            bout_q <= bo_bit;
            ovf_q  <= br_q ^ bo_bit;
         end
      end
   end

   assign diff = diff_q;
   assign bout = bout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=13.
// Drivers push expected results; monitors pop on each accepted output.
module tb_serial_subtractor;

   typedef struct {
      logic [15:0] d;
      logic        bo;
      logic        ov;
      int          acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int failures = 0;

   logic        v8 = 0, r8, ov8, or8 = 1, bin8 = 0, bo8, of8;
   logic [7:0]  a8 = 0, b8 = 0, d8;
   logic        v13 = 0, r13, ov13, or13 = 1, bin13 = 0, bo13, of13;
   logic [12:0] a13 = 0, b13 = 0, d13;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(v8), .in_ready(r8),
      .a(a8), .b(b8), .bin(bin8),
      .out_valid(ov8), .out_ready(or8),
      .diff(d8), .bout(bo8), .ovf(of8)
   );

   serial_subtractor #(.WIDTH(13)) dut13 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(v13), .in_ready(r13),
      .a(a13), .b(b13), .bin(bin13),
      .out_valid(ov13), .out_ready(or13),
      .diff(d13), .bout(bo13), .ovf(of13)
   );

   exp_t q8[$];
   exp_t q13[$];

   task automatic chk(string n, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", n, act, req);
      end
   endtask

   function automatic exp_t model(int w, int a, int b, int bin);
      exp_t e;
      int full = 1 << w;
      int half = 1 << (w - 1);
      int r = a - b - bin;
      int sa = (a >= half) ? a - full : a;
      int sb = (b >= half) ? b - full : b;
      int s = sa - sb - bin;
      e.d   = 16'(r & (full - 1));
      e.bo  = (r < 0);
      e.ov  = (s < -half) || (s > half - 1);
      e.acc = 0;
      return e;
   endfunction

   task automatic send8(logic [7:0] a, logic [7:0] b, logic bin,
                        logic [7:0] ed, logic ebo, logic eov);
      exp_t e;
      int n = 0;
      @(negedge clk);
      a8 = a; b8 = b; bin8 = bin; v8 = 1;
      while (!r8 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!r8) begin
         chk("accept_timeout8", 0, 1);
         v8 = 0;
         return;
      end
      @(posedge clk);
      #1;
      e.d = 16'(ed); e.bo = ebo; e.ov = eov; e.acc = cyc;
      q8.push_back(e);
      v8 = 0;
   endtask

   task automatic send13(logic [12:0] a, logic [12:0] b, logic bin,
                         exp_t e);
      int n = 0;
      @(negedge clk);
      a13 = a; b13 = b; bin13 = bin; v13 = 1;
      while (!r13 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!r13) begin
         chk("accept_timeout13", 0, 1);
         v13 = 0;
         return;
      end
      @(posedge clk);
      #1;
      e.acc = cyc;
      q13.push_back(e);
      v13 = 0;
   endtask

   task automatic drain(int budget);
      int n = 0;
      while ((q8.size() != 0 || q13.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", q8.size() + q13.size(), 0);
   endtask

   int  f8, f13;
   bit  s8 = 0, s13 = 0;

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) s8 = 0;
      if (rst_n && ov8 && !s8) begin
         s8 = 1;
         f8 = cyc;
      end
      if (rst_n && ov8 && or8) begin
         if (q8.size() == 0) chk("unexpected_out8", 1, 0);
         else begin
            e = q8.pop_front();
            chk("diff8", 32'(d8), 32'(e.d));
            chk("bout8", 32'(bo8), 32'(e.bo));
            chk("ovf8", 32'(of8), 32'(e.ov));
            chk("lat8", f8 - e.acc, 8);
         end
         s8 = 0;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) s13 = 0;
      if (rst_n && ov13 && !s13) begin
         s13 = 1;
         f13 = cyc;
      end
      if (rst_n && ov13 && or13) begin
         if (q13.size() == 0) chk("unexpected_out13", 1, 0);
         else begin
            e = q13.pop_front();
            chk("diff13", 32'(d13), 32'(e.d));
            chk("bout13", 32'(bo13), 32'(e.bo));
            chk("ovf13", 32'(of13), 32'(e.ov));
            chk("lat13", f13 - e.acc, 13);
         end
         s13 = 0;
      end
   end

   initial begin
      int n;
      #12;
      chk("rst_in_ready", 32'(r8), 1);
      chk("rst_out_valid", 32'(ov8), 0);
      chk("rst_diff", 32'(d8), 0);
      chk("rst_bout_ovf", {30'd0, bo8, of8}, 0);
      @(negedge clk);
      rst_n = 1;

      send8(8'd100, 8'd37, 1'b0, 8'd63, 1'b0, 1'b0);
      send8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
      send8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
      send8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
      send8(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
      send8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
      drain(100);

      // Result held in DONE while the consumer stalls
      or8 = 0;
      send8(8'h55, 8'h22, 1'b1, 8'h32, 1'b0, 1'b0);
      n = 0;
      while (!ov8 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("hold_reach_done", 32'(ov8), 1);
      a8 = 8'h11; b8 = 8'h99; bin8 = 1; v8 = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_valid", 32'(ov8), 1);
         chk("hold_in_ready", 32'(r8), 0);
         chk("hold_diff", 32'(d8), 32'h32);
         chk("hold_flags", {30'd0, bo8, of8}, 0);
      end
      v8 = 0;
      or8 = 1;
      drain(20);
      @(negedge clk);
      chk("after_hold_idle", 32'(r8), 1);
      send8(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);
      drain(100);

      // Asynchronous reset part-way through an operation
      send8(8'hC3, 8'h5A, 1'b0, 8'h69, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 0;
      #1;
      chk("arst_out_valid", 32'(ov8), 0);
      chk("arst_in_ready", 32'(r8), 1);
      chk("arst_diff", 32'(d8), 0);
      chk("arst_flags", {30'd0, bo8, of8}, 0);
      q8.delete();
      repeat (2) @(negedge clk);
      rst_n = 1;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (ov8) n++;
      end
      chk("no_valid_after_rst", n, 0);
      send8(8'd5, 8'd3, 1'b0, 8'd2, 1'b0, 1'b0);
      drain(100);

      fork
         for (int i = 0; i < 1000; i++) begin
            int ra = $urandom_range(0, 255);
            int rb = $urandom_range(0, 255);
            int rc = $urandom_range(0, 1);
            exp_t e = model(8, ra, rb, rc);
            send8(8'(ra), 8'(rb), 1'(rc), e.d[7:0], e.bo, e.ov);
         end
         for (int i = 0; i < 1000; i++) begin
            int ra = $urandom_range(0, 8191);
            int rb = $urandom_range(0, 8191);
            int rc = $urandom_range(0, 1);
            send13(13'(ra), 13'(rb), 1'(rc), model(13, ra, rb, rc));
         end
      join
      drain(200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (>= 2).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  input  1  operands a, b, bin are valid.
REQ-005 Port: in_ready  output  1  block can accept operands.
REQ-006 Port: a  input  WIDTH  minuend.
REQ-007 Port: b  input  WIDTH  subtrahend.
REQ-008 Port: bin  input  1  borrow-in.
REQ-009 Port: out_valid  output  1  diff, bout and ovf are valid.
REQ-010 Port: out_ready  input  1  consumer accepts the result.
REQ-011 Port: diff  output  WIDTH  result of a - b - bin, modulo 2^WIDTH.
REQ-012 Port: bout  output  1  final borrow-out (unsigned a < b + bin).
REQ-013 Port: ovf  output  1  two's-complement signed overflow of the subtraction.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-015 IDLE: in_ready=1, out_valid=0; an edge with in_valid=1 SHALL capture a, b and bin into internal registers, clear the bit counter, and enter BUSY.
REQ-016 BUSY: in_ready=0, out_valid=0; each edge SHALL subtract one bit, LSB first, using a single 1-bit full subtractor: d = ai^bi^br, borrow_next = (~ai&bi) | (~(ai^bi)&br).
REQ-017 The borrow register SHALL be loaded with bin on capture and updated with borrow_next on each BUSY edge.
REQ-018 Each result bit SHALL shift into the diff register from the MSB side, so that diff is aligned LSB-correct after WIDTH shifts.
REQ-019 After exactly WIDTH BUSY edges, the FSM SHALL enter DONE.
REQ-020 Latency: with in_valid accepted at edge E0, out_valid SHALL be 1 immediately after edge E(WIDTH).
REQ-021 DONE: out_valid=1, in_ready=0; diff, bout and ovf SHALL hold stable until an edge with out_ready=1, which returns the FSM to IDLE.
REQ-022 ovf SHALL equal the borrow into the MSB XOR the borrow out of the MSB; it is captured on the final BUSY edge.
REQ-023 in_valid while BUSY or DONE SHALL be ignored, with no capture; a, b and bin are don't-care outside IDLE.
REQ-024 out_ready outside DONE SHALL have no effect.
REQ-025 Back-to-back operation: the earliest next capture is the edge after the DONE-to-IDLE edge; there is no result-to-accept bypass.
REQ-026 Bit counter width: $clog2(WIDTH)+1 bits; it SHALL NOT wrap during BUSY.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for clk, force: FSM to IDLE; in_ready=1; out_valid=0; diff=0; bout=0; ovf=0; counter, borrow and operand registers to 0.
REQ-028 Reset asserted mid-BUSY or in DONE SHALL discard the operation; no out_valid pulse SHALL follow.
REQ-029 On reset release, the first capture is possible at the first rising edge with rst_n=1 and in_valid=1.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-031 The 1-bit datapath SHALL be a sub-module named full_subtractor (inputs a, b, bi; outputs d, bo), instantiated once with name-based port connection.
REQ-032 The borrow logic SHALL be purely combinational inside full_subtractor; all registers reside in serial_subtractor.

Verification
REQ-033 a=100, b=37, bin=0 -> diff=63, bout=0, ovf=0; out_valid exactly 8 cycles after the accept edge.
REQ-034 a=0, b=1, bin=0 -> diff=8'hFF, bout=1, ovf=0; a=0, b=0, bin=1 -> diff=8'hFF, bout=1.
REQ-035 a=8'h80, b=8'h01, bin=0 -> diff=8'h7F, bout=0, ovf=1; a=8'h7F, b=8'hFF -> diff=8'h80, ovf=1, bout=1.
REQ-036 Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, a new in_valid is ignored; out_ready=1 -> IDLE, next operation correct.
REQ-037 Assert rst_n=0 at BUSY bit 3 -> outputs zero immediately without a clock edge, no out_valid; after release, a=5, b=3 -> diff=2.
REQ-038 Random sweep of 1000 vectors with WIDTH=8 and WIDTH=13 against a reference model {bout, diff} = a - b - bin, checking ovf and latency.
